// File: rtl/shift_reg_universal.sv
// shift_reg_universal: WIDTH-bit universal shift register (hold, shift right,
// shift left, parallel load) with serial taps at both ends and a frame
// counter that pulses frame_done after every WIDTH consecutive shifts.
//
// Build option: define SHIFT_ROTATE_EN to turn both shift directions into
// rotates (serial inputs ignored); default build uses ser_in_r / ser_in_l.
module shift_reg_universal #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  output logic [WIDTH-1:0] d_out,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // Terminal count: the WIDTH-th shift of a frame happens when the counter
  // already reads WIDTH-1, so the counter never needs to hold WIDTH itself.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_shr;
  logic [WIDTH-1:0] data_shl;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             fill_r;
  logic             fill_l;
  logic             cnt_at_last;

  // Select the bit entering each end of the register on a shift.
  always_comb begin
`ifdef SHIFT_ROTATE_EN
    fill_r = data_q[0];
    fill_l = data_q[WIDTH-1];
`else
    fill_r = ser_in_r;
    fill_l = ser_in_l;
`endif
  end

  // Candidate next values for both shift directions.
  always_comb begin
    data_shr = {fill_r, data_q[WIDTH-1:1]};
    data_shl = {data_q[WIDTH-2:0], fill_l};
  end

  assign cnt_at_last = (cnt_q == CNT_LAST);

  // Register contents; reset wins over every mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      unique case (mode)
        MODE_HOLD: data_q <= data_q;
        MODE_SHR:  data_q <= data_shr;
        MODE_SHL:  data_q <= data_shl;
        MODE_LOAD: data_q <= d_in;
        default:   data_q <= data_q;
      endcase
    end
  end

  // Shift counter and frame pulse; both shift directions share one count,
  // and a load or reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      unique case (mode)
        MODE_SHR, MODE_SHL: begin
          if (cnt_at_last) begin
            cnt_q  <= '0;
            done_q <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + CNT_ONE;
            done_q <= 1'b0;
          end
        end
        MODE_LOAD: begin
          cnt_q  <= '0;
          done_q <= 1'b0;
        end
        default: begin
          cnt_q  <= cnt_q;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign d_out      = data_q;
  assign ser_out_r  = data_q[0];
  assign ser_out_l  = data_q[WIDTH-1];
  assign shift_cnt  = cnt_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_shift_reg_universal.sv
// tb_shift_reg_universal: directed-vector bench for shift_reg_universal
// (WIDTH=4). Expected values are hand-computed constants.
module tb_shift_reg_universal;

  logic       clk;
  logic       reset;
  logic [1:0] mode;
  logic [3:0] d_in;
  logic       ser_in_r;
  logic       ser_in_l;
  logic [3:0] d_out;
  logic       ser_out_r;
  logic       ser_out_l;
  logic [2:0] shift_cnt;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  shift_reg_universal #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .d_in       (d_in),
    .ser_in_r   (ser_in_r),
    .ser_in_l   (ser_in_l),
    .d_out      (d_out),
    .ser_out_r  (ser_out_r),
    .ser_out_l  (ser_out_l),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one set of inputs across a rising edge, then settle before sampling.
  task automatic step(input logic rst, input logic [1:0] m, input logic [3:0] d,
                      input logic sr, input logic sl);
    reset    = rst;
    mode     = m;
    d_in     = d;
    ser_in_r = sr;
    ser_in_l = sl;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] d,
                              input logic [2:0] c, input logic f);
    chk({tag, ".d_out"}, 32'(d_out), 32'(d));
    chk({tag, ".cnt"}, 32'(shift_cnt), 32'(c));
    chk({tag, ".done"}, 32'(frame_done), 32'(f));
  endtask

  initial begin
    reset = 1'b1; mode = 2'b11; d_in = 4'hF; ser_in_r = 1'b0; ser_in_l = 1'b0;

    // Reset with load requested: reset must win.
    step(1'b1, 2'b11, 4'hF, 1'b0, 1'b0);
    step(1'b1, 2'b11, 4'hF, 1'b0, 1'b0);
    expect_state("reset", 4'h0, 3'd0, 1'b0);

    // Parallel load then hold.
    step(1'b0, 2'b11, 4'b1001, 1'b0, 1'b0);
    expect_state("load", 4'b1001, 3'd0, 1'b0);
    chk("pipo.ser_out_r", 32'(ser_out_r), 32'd1);
    chk("pipo.ser_out_l", 32'(ser_out_l), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, 4'b0110, 1'b1, 1'b1);
      expect_state("hold", 4'b1001, 3'd0, 1'b0);
    end

`ifdef SHIFT_ROTATE_EN
    // Right rotate: ser_in_r must be ignored.
    step(1'b0, 2'b11, 4'b1000, 1'b0, 1'b0);
    step(1'b0, 2'b01, 4'h0, 1'b1, 1'b1);
    expect_state("rot1", 4'b0100, 3'd1, 1'b0);
    step(1'b0, 2'b01, 4'h0, 1'b1, 1'b1);
    expect_state("rot2", 4'b0010, 3'd2, 1'b0);
    step(1'b0, 2'b01, 4'h0, 1'b1, 1'b1);
    expect_state("rot3", 4'b0001, 3'd3, 1'b0);
    step(1'b0, 2'b01, 4'h0, 1'b1, 1'b1);
    expect_state("rot4", 4'b1000, 3'd0, 1'b1);
    step(1'b0, 2'b00, 4'h0, 1'b0, 1'b0);
    expect_state("rot_hold", 4'b1000, 3'd0, 1'b0);
    // Left rotate: ser_in_l must be ignored.
    step(1'b0, 2'b11, 4'b1010, 1'b0, 1'b0);
    step(1'b0, 2'b10, 4'h0, 1'b0, 1'b0);
    expect_state("rotl1", 4'b0101, 3'd1, 1'b0);
`else
    // SIPO right: ser_in_r = 1,0,1,1.
    step(1'b0, 2'b11, 4'h0, 1'b0, 1'b0);
    step(1'b0, 2'b01, 4'h0, 1'b1, 1'b0);
    expect_state("sipo1", 4'b1000, 3'd1, 1'b0);
    step(1'b0, 2'b01, 4'h0, 1'b0, 1'b0);
    expect_state("sipo2", 4'b0100, 3'd2, 1'b0);
    step(1'b0, 2'b01, 4'h0, 1'b1, 1'b0);
    expect_state("sipo3", 4'b1010, 3'd3, 1'b0);
    step(1'b0, 2'b01, 4'h0, 1'b1, 1'b0);
    expect_state("sipo4", 4'b1101, 3'd0, 1'b1);
    step(1'b0, 2'b00, 4'h0, 1'b0, 1'b0);
    expect_state("sipo_hold", 4'b1101, 3'd0, 1'b0);

    // PISO left with ser_in_l=0: ser_out_l before each shift is 1,0,1,0.
    step(1'b0, 2'b11, 4'b1010, 1'b0, 1'b0);
    chk("piso.out_l0", 32'(ser_out_l), 32'd1);
    step(1'b0, 2'b10, 4'h0, 1'b1, 1'b0);
    expect_state("piso1", 4'b0100, 3'd1, 1'b0);
    chk("piso.out_l1", 32'(ser_out_l), 32'd0);
    step(1'b0, 2'b10, 4'h0, 1'b1, 1'b0);
    expect_state("piso2", 4'b1000, 3'd2, 1'b0);
    chk("piso.out_l2", 32'(ser_out_l), 32'd1);
    step(1'b0, 2'b10, 4'h0, 1'b1, 1'b0);
    expect_state("piso3", 4'b0000, 3'd3, 1'b0);
    chk("piso.out_l3", 32'(ser_out_l), 32'd0);
    step(1'b0, 2'b10, 4'h0, 1'b1, 1'b0);
    expect_state("piso4", 4'b0000, 3'd0, 1'b1);

    // Left shift brings ser_in_l into the LSB; ser_out_r taps it.
    step(1'b0, 2'b11, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 2'b10, 4'h0, 1'b0, 1'b1);
    expect_state("shl_in", 4'b0001, 3'd1, 1'b0);
    chk("shl_in.ser_out_r", 32'(ser_out_r), 32'd1);
`endif

    // Continuous shifting: pulse after shift 4 and shift 8, none between.
    step(1'b0, 2'b11, 4'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 2'b01, 4'h0, 1'b0, 1'b0);
      chk($sformatf("cont%0d.cnt", i), 32'(shift_cnt), 32'(i % 4));
      chk($sformatf("cont%0d.done", i), 32'(frame_done), 32'((i % 4) == 0));
    end
    // Load right after completion clears the flag.
    step(1'b0, 2'b11, 4'h3, 1'b0, 1'b0);
    expect_state("load_after_done", 4'h3, 3'd0, 1'b0);

    // Direction change mid-frame keeps counting.
    step(1'b0, 2'b01, 4'h0, 1'b0, 1'b0);
    step(1'b0, 2'b01, 4'h0, 1'b0, 1'b0);
    chk("dir.mid_cnt", 32'(shift_cnt), 32'd2);
    step(1'b0, 2'b10, 4'h0, 1'b0, 1'b0);
    step(1'b0, 2'b10, 4'h0, 1'b0, 1'b0);
    chk("dir.cnt", 32'(shift_cnt), 32'd0);
    chk("dir.done", 32'(frame_done), 32'd1);

    // Load mid-frame discards partial count.
    step(1'b0, 2'b01, 4'h0, 1'b0, 1'b0);
    step(1'b0, 2'b11, 4'h6, 1'b0, 1'b0);
    expect_state("load_mid", 4'h6, 3'd0, 1'b0);

    // Abort: 2 shifts, reset, then 4 shifts -> single pulse at the end.
    step(1'b0, 2'b11, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 2'b01, 4'h0, 1'b0, 1'b0);
    step(1'b0, 2'b01, 4'h0, 1'b0, 1'b0);
    chk("abort.cnt_pre", 32'(shift_cnt), 32'd2);
    step(1'b1, 2'b01, 4'h0, 1'b0, 1'b0);
    expect_state("abort.reset", 4'h0, 3'd0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 2'b01, 4'h0, 1'b0, 1'b0);
      chk($sformatf("abort%0d.done", i), 32'(frame_done), 32'(i == 4));
    end

    // Reset in the cycle after a completion: pulse shown, then cleared.
    step(1'b1, 2'b00, 4'h0, 1'b0, 1'b0);
    expect_state("reset_after_done", 4'h0, 3'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
